// File: rtl/adder_seq_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : adder_seq_pkg
//  Description : Shared definitions for the multi-precision add/subtract
//                sequencer: sequencer state encoding, byte width, and the
//                signed-overflow helper used on the most-significant byte.
//  Revision    : 1.0 - initial release
// ============================================================================
package adder_seq_pkg;

    localparam int BYTE_W = 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } seq_state_t;

    // Two's-complement overflow: both addends share a sign and the result's
    // sign differs from it. b_msb is the sign of the (possibly inverted)
    // operand actually fed to the adder.
    function automatic logic ovf_calc(input logic a_msb,
                                      input logic b_msb,
                                      input logic s_msb);
        return (a_msb == b_msb) && (s_msb != a_msb);
    endfunction

endpackage
`default_nettype wire

// File: rtl/adder.sv
`default_nettype none
// ============================================================================
//  Module      : adder
//  Description : 8-bit Kogge-Stone prefix adder with carry-in.
//  Ports       : a, b  - 8-bit addends
//                cin   - carry-in
//                sum   - 8-bit sum
//                cout  - carry-out of bit 7
//  Revision    : 1.0 - initial release
// ============================================================================
module adder (
    output logic       cout,
    output logic [7:0] sum,
    input  logic [7:0] a,
    input  logic [7:0] b,
    input  logic       cin
);

    // w_g[s]/w_p[s]: group generate/propagate after prefix stage s.
    logic [7:0] w_g [0:3];
    logic [7:0] w_p [0:3];
    logic [7:0] w_carry;

    always_comb begin
        w_g[0] = a & b;
        w_p[0] = a ^ b;
        // Fold the carry-in into bit 0 so the prefix tree carries it along.
        w_g[0][0] = (a[0] & b[0]) | ((a[0] ^ b[0]) & cin);
        for (int s = 0; s < 3; s++) begin
            w_g[s+1] = w_g[s];
            w_p[s+1] = w_p[s];
            for (int i = 0; i < 8; i++) begin
                if (i >= (1 << s)) begin
                    w_g[s+1][i] = w_g[s][i] | (w_p[s][i] & w_g[s][i - (1 << s)]);
                    w_p[s+1][i] = w_p[s][i] & w_p[s][i - (1 << s)];
                end
            end
        end
        w_carry = {w_g[3][6:0], cin};
        sum     = (a ^ b) ^ w_carry;
        cout    = w_g[3][7];
    end

endmodule
`default_nettype wire

// File: rtl/adder_mp_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : adder_mp_sequencer
//  Description : Multi-precision add/subtract sequencer. Operands of
//                NBYTES bytes are pushed through one 8-bit adder LSB first,
//                one byte per cycle, with the carry chained through a
//                register between bytes.
//  Ports       : clk, rst            - clock, synchronous active-high reset
//                in_valid/in_ready   - request handshake
//                in_a, in_b          - operands (8*NBYTES bits)
//                in_sub, in_cin      - subtract select, carry/borrow-in
//                out_valid/out_ready - result handshake
//                out_sum             - result (8*NBYTES bits)
//                out_cout            - final carry (sub: 1 = no borrow)
//                out_ovf             - signed overflow of the full result
//  Revision    : 1.0 - initial release
// ============================================================================
module adder_mp_sequencer
    import adder_seq_pkg::*;
#(
    parameter int NBYTES = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [BYTE_W*NBYTES-1:0]   in_a,
    input  logic [BYTE_W*NBYTES-1:0]   in_b,
    input  logic                       in_sub,
    input  logic                       in_cin,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [BYTE_W*NBYTES-1:0]   out_sum,
    output logic                       out_cout,
    output logic                       out_ovf
);

    localparam int               C_W     = BYTE_W * NBYTES;
    localparam int               C_IDX_W = (NBYTES > 1) ? $clog2(NBYTES) : 1;
    localparam logic [C_IDX_W-1:0] C_LAST = C_IDX_W'(NBYTES - 1);

    seq_state_t           r_state;
    logic [C_IDX_W-1:0]   r_idx;
    logic                 r_carry;
    logic [C_W-1:0]       r_op_a;
    logic [C_W-1:0]       r_op_b;

    logic [BYTE_W-1:0]    w_byte_a;
    logic [BYTE_W-1:0]    w_byte_b;
    logic [BYTE_W-1:0]    w_sum;
    logic                 w_cout;

    assign in_ready = (r_state == IDLE) && !rst;

    assign w_byte_a = r_op_a[BYTE_W*r_idx +: BYTE_W];
    assign w_byte_b = r_op_b[BYTE_W*r_idx +: BYTE_W];

    adder u_adder (
        .cout (w_cout),
        .sum  (w_sum),
        .a    (w_byte_a),
        .b    (w_byte_b),
        .cin  (r_carry)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= IDLE;
            r_idx     <= '0;
            r_carry   <= 1'b0;
            r_op_a    <= '0;
            r_op_b    <= '0;
            out_valid <= 1'b0;
            out_sum   <= '0;
            out_cout  <= 1'b0;
            out_ovf   <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (in_valid) begin
                        // Subtraction is A + ~B + ~borrow_in.
                        r_op_a  <= in_a;
                        r_op_b  <= in_sub ? ~in_b : in_b;
                        r_carry <= in_sub ? ~in_cin : in_cin;
                        r_idx   <= '0;
                        r_state <= RUN;
                    end
                end
                RUN: begin
                    out_sum[BYTE_W*r_idx +: BYTE_W] <= w_sum;
                    r_carry <= w_cout;
                    r_idx   <= r_idx + 1'b1;
                    if (r_idx == C_LAST) begin
                        out_cout  <= w_cout;
                        out_ovf   <= ovf_calc(r_op_a[C_W-1], r_op_b[C_W-1],
                                              w_sum[BYTE_W-1]);
                        out_valid <= 1'b1;
                        r_state   <= DONE;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        r_state   <= IDLE;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_adder_mp_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_adder_mp_sequencer
//  Description : Self-checking bench for adder_mp_sequencer. Two instances
//                (NBYTES=4 and NBYTES=1) are checked every cycle against an
//                arithmetic model of the expected result, latency and
//                handshake; directed cases add literal expectations.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_adder_mp_sequencer;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic             rst;
    logic [1:0]       in_valid_v, in_sub_v, in_cin_v, out_ready_v;
    logic [1:0][31:0] in_a_v, in_b_v;
    logic [1:0]       in_ready_v, out_valid_v, out_cout_v, out_ovf_v;
    logic [1:0][31:0] out_sum_v;

    int     total = 0;
    int     bad   = 0;
    longint cyc   = 0;
    bit     chk_en   = 1'b0;
    bit     rnd_mode = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input longint act, input longint exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    for (genvar k = 0; k < 2; k++) begin : g_dut
        localparam int NB = (k == 0) ? 4 : 1;
        localparam int W  = 8 * NB;

        logic [W-1:0] sum_w;

        adder_mp_sequencer #(.NBYTES(NB)) u_dut (
            .clk       (clk),
            .rst       (rst),
            .in_valid  (in_valid_v[k]),
            .in_ready  (in_ready_v[k]),
            .in_a      (in_a_v[k][W-1:0]),
            .in_b      (in_b_v[k][W-1:0]),
            .in_sub    (in_sub_v[k]),
            .in_cin    (in_cin_v[k]),
            .out_valid (out_valid_v[k]),
            .out_ready (out_ready_v[k]),
            .out_sum   (sum_w),
            .out_cout  (out_cout_v[k]),
            .out_ovf   (out_ovf_v[k])
        );
        assign out_sum_v[k] = 32'(sum_w);

        typedef struct {
            longint sum;
            bit     cout;
            bit     ovf;
            longint due;
        } exp_t;

        exp_t q[$];
        int   done_cnt = 0;

        // Result from plain integer arithmetic on the W-bit operands.
        function automatic exp_t model(bit sub, longint a, longint b, bit cin, longint due);
            exp_t   e;
            longint m  = (longint'(1) << W) - 1;
            longint h  = longint'(1) << (W - 1);
            longint au = a & m;
            longint bu = b & m;
            longint as_ = (au >= h) ? au - (m + 1) : au;
            longint bs  = (bu >= h) ? bu - (m + 1) : bu;
            longint ru, rs;
            if (!sub) begin
                ru = au + bu + longint'(cin);
                rs = as_ + bs + longint'(cin);
                e.cout = (ru > m);
            end else begin
                ru = au - bu - longint'(cin);
                rs = as_ - bs - longint'(cin);
                e.cout = (ru >= 0);
            end
            e.sum = ru & m;
            e.ovf = (rs >= h) || (rs < -h);
            e.due = due;
            return e;
        endfunction

        always @(negedge clk) begin
            if (chk_en) begin
                if (rst) begin
                    check($sformatf("u%0d in_ready_in_reset", k), in_ready_v[k], 0);
                    q.delete();
                end else begin
                    check($sformatf("u%0d in_ready", k), in_ready_v[k], (q.size() == 0));
                    if (q.size() == 0) begin
                        check($sformatf("u%0d out_valid_idle", k), out_valid_v[k], 0);
                    end else if (cyc < q[0].due) begin
                        check($sformatf("u%0d out_valid_early", k), out_valid_v[k], 0);
                    end else begin
                        check($sformatf("u%0d out_valid", k), out_valid_v[k], 1);
                        check($sformatf("u%0d out_sum", k), out_sum_v[k], q[0].sum);
                        check($sformatf("u%0d out_cout", k), out_cout_v[k], q[0].cout);
                        check($sformatf("u%0d out_ovf", k), out_ovf_v[k], q[0].ovf);
                        if (out_valid_v[k] && out_ready_v[k]) begin
                            void'(q.pop_front());
                            done_cnt++;
                        end
                    end
                    if (in_valid_v[k] && in_ready_v[k])
                        q.push_back(model(in_sub_v[k], longint'(in_a_v[k]), longint'(in_b_v[k]),
                                          in_cin_v[k], cyc + 1 + NB));
                end
            end
        end
    end

    // Waits for acceptance of one request; entered and left at posedge+1.
    task automatic send(input int k, input bit sub, input logic [31:0] a,
                        input logic [31:0] b, input bit cin);
        bit acc = 1'b0;
        int n = 0;
        in_valid_v[k] = 1'b1; in_sub_v[k] = sub; in_cin_v[k] = cin;
        in_a_v[k] = a; in_b_v[k] = b;
        while (!acc && n < 400) begin
            @(negedge clk);
            acc = in_ready_v[k];
            @(posedge clk); #1;
            n++;
        end
        if (!acc) begin
            total++; bad++;
            $display("FAIL u%0d accept_timeout: got no accept expected accept", k);
        end
        // Scramble inputs after acceptance; registered operands must not care.
        in_valid_v[k] = 1'b0;
        in_a_v[k] = $urandom; in_b_v[k] = $urandom;
        in_sub_v[k] = 1'($urandom); in_cin_v[k] = 1'($urandom);
    endtask

    task automatic expect_res(input string nm, input logic [31:0] s, input bit c,
                              input bit o, input int lat);
        bit seen = 1'b0;
        int n = 0;
        while (!seen && n < 100) begin
            @(negedge clk);
            n++;
            seen = out_valid_v[0];
        end
        if (!seen) begin
            total++; bad++;
            $display("FAIL %s result_timeout: got no out_valid expected out_valid", nm);
        end else begin
            check({nm, " sum"}, out_sum_v[0], longint'(s));
            check({nm, " cout"}, out_cout_v[0], c);
            check({nm, " ovf"}, out_ovf_v[0], o);
            if (lat > 0) check({nm, " latency"}, n, lat);
        end
        @(posedge clk); #1;
    endtask

    task automatic rand_ops(input int k, input int nops);
        logic [31:0] pick [5];
        for (int i = 0; i < nops; i++) begin
            repeat ($urandom_range(0, 3)) begin @(posedge clk); #1; end
            pick[0] = 32'h0; pick[1] = 32'hFFFF_FFFF; pick[2] = $urandom;
            pick[3] = (k == 0) ? 32'h8000_0000 : 32'h80;
            pick[4] = (k == 0) ? 32'h7FFF_FFFF : 32'h7F;
            send(k, 1'($urandom), pick[$urandom_range(0, 4)], pick[$urandom_range(0, 4)],
                 1'($urandom));
        end
    endtask

    initial begin
        forever begin
            @(posedge clk); #1;
            if (rnd_mode) out_ready_v = 2'($urandom);
        end
    end

    initial begin
        int d0, d1, n;
        rst = 1'b1;
        in_valid_v = '0; in_sub_v = '0; in_cin_v = '0; out_ready_v = 2'b11;
        in_a_v = '0; in_b_v = '0;
        @(posedge clk); #1;
        chk_en = 1'b1;
        repeat (2) begin @(posedge clk); #1; end
        rst = 1'b0;

        // Reset state
        @(negedge clk);
        check("reset out_valid", out_valid_v[0], 0);
        check("reset out_sum", out_sum_v[0], 0);
        check("reset out_cout", out_cout_v[0], 0);
        check("reset out_ovf", out_ovf_v[0], 0);
        check("reset in_ready", in_ready_v[0], 1);
        @(posedge clk); #1;

        send(0, 0, 32'hFFFF_FFFF, 32'h0000_0001, 0);
        expect_res("add_wrap", 32'h0000_0000, 1, 0, 5);
        send(0, 0, 32'h7FFF_FFFF, 32'h0000_0001, 0);
        expect_res("add_ovf", 32'h8000_0000, 0, 1, 5);
        send(0, 1, 32'h0000_0005, 32'h0000_0007, 0);
        expect_res("sub_borrow", 32'hFFFF_FFFE, 0, 0, 5);
        send(0, 1, 32'h0000_0005, 32'h0000_0003, 0);
        expect_res("sub_noborrow", 32'h0000_0002, 1, 0, 5);

        // Backpressure: result held, new request stalled
        out_ready_v[0] = 1'b0;
        send(0, 0, 32'h0000_00FF, 32'h0000_0001, 0);
        expect_res("hold_first", 32'h0000_0100, 0, 0, 5);
        in_valid_v[0] = 1'b1; in_sub_v[0] = 1'b0; in_cin_v[0] = 1'b1;
        in_a_v[0] = 32'h4000_0000; in_b_v[0] = 32'h4000_0000;
        repeat (10) begin
            @(negedge clk);
            check("hold out_valid", out_valid_v[0], 1);
            check("hold out_sum", out_sum_v[0], 32'h0000_0100);
            check("hold in_ready", in_ready_v[0], 0);
            @(posedge clk); #1;
        end
        out_ready_v[0] = 1'b1;
        send(0, 0, 32'h4000_0000, 32'h4000_0000, 1);
        expect_res("stalled_op", 32'h8000_0001, 0, 1, 5);

        // Reset in the middle of a run (idx==2)
        send(0, 0, 32'hAAAA_AAAA, 32'h5555_5555, 0);
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        check("midrst out_valid", out_valid_v[0], 0);
        check("midrst in_ready", in_ready_v[0], 1);
        @(posedge clk); #1;
        send(0, 0, 32'h1234_5678, 32'h1111_1111, 0);
        expect_res("after_rst", 32'h2345_6789, 0, 0, 5);

        // Random traffic on both widths with random backpressure
        d0 = g_dut[0].done_cnt;
        d1 = g_dut[1].done_cnt;
        rnd_mode = 1'b1;
        fork
            rand_ops(0, 1000);
            rand_ops(1, 1000);
        join
        rnd_mode = 1'b0;
        @(posedge clk); #2;
        out_ready_v = 2'b11;
        n = 0;
        while ((g_dut[0].q.size() != 0 || g_dut[1].q.size() != 0) && n < 200) begin
            @(posedge clk); #1;
            n++;
        end
        @(negedge clk);
        check("u0 drained", g_dut[0].q.size(), 0);
        check("u1 drained", g_dut[1].q.size(), 0);
        check("u0 completed", g_dut[0].done_cnt - d0, 1000);
        check("u1 completed", g_dut[1].done_cnt - d1, 1000);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: got no finish expected finish");
        $fatal(1, "timeout");
    end

endmodule
`default_nettype wire

// File: doc/adder_mp_sequencer.md
Name: adder_mp_sequencer

Overview:
- Multi-precision add/subtract sequencer around one instance of the existing 8-bit prefix `adder` (ports cout, sum, a, b, cin).
- Accepts NBYTES-wide operands over a valid/ready handshake and feeds them through the adder one byte per cycle, LSB first.
- The registered carry-out of each byte is chained into the next byte's carry-in.
- Returns the full sum, final carry and signed overflow over a second valid/ready handshake.
- Sits between the ALU front-end and the shared 8-bit adder datapath.

Parameters:
NBYTES, 4, operand width in bytes (legal range ≥1); full operand width W = 8*NBYTES

Ports:
clk  input  1  clock, all state updates on rising edge
rst  input  1  reset, synchronous, active-high
in_valid  input  1  request operands valid
in_ready  output  1  block can accept a request
in_a  input  W  operand A
in_b  input  W  operand B
in_sub  input  1  1 = subtract (A - B), 0 = add
in_cin  input  1  carry-in (add) / borrow-in (sub)
out_valid  output  1  result valid
out_ready  input  1  consumer accepts result
out_sum  output  W  result
out_cout  output  1  final carry (sub: 1 = no borrow)
out_ovf  output  1  signed two's-complement overflow of the W-bit result

Behaviour:
- Clock/reset: single clock clk; reset rst is synchronous, active-high.
- Reset: state=IDLE, idx=0, carry=0, out_valid=0, out_sum=0, out_cout=0, out_ovf=0. in_ready is 0 while rst=1.
- FSM states IDLE, RUN, DONE.
- IDLE:
  - in_ready = 1 (and rst=0).
  - On in_valid & in_ready: capture opA=in_a.
  - Capture opB = in_sub ? ~in_b : in_b.
  - Capture carry = in_sub ? ~in_cin : in_cin.
  - Set idx=0, go to RUN.
- RUN:
  - Adder inputs: a=opA[8*idx +: 8], b=opB[8*idx +: 8], cin=carry (combinational, within this cycle).
  - Each cycle: out_sum[8*idx +: 8] <= sum, carry <= cout, idx <= idx+1.
  - On idx==NBYTES-1: also set out_cout <= cout.
  - On idx==NBYTES-1: also set out_ovf <= (opA[W-1]==opB[W-1]) & (sum[7]!=opA[W-1]).
  - On idx==NBYTES-1: also set out_valid <= 1 and go to DONE.
- DONE:
  - out_valid=1; out_sum/out_cout/out_ovf held stable until handshake.
  - On out_ready: out_valid <= 0, go to IDLE.
- Latency: request accepted at edge T gives out_valid=1 from edge T+NBYTES.
- Throughput: one op per NBYTES+2 cycles with out_ready tied high.
- in_ready is asserted only in IDLE, so a request presented during RUN/DONE is stalled, never dropped.
- in_a/in_b changes after acceptance have no effect (operands are registered).
- out_ready while out_valid=0 is ignored.
- NBYTES=1: RUN lasts one cycle; idx width is max(1, clog2(NBYTES)).
- Reset mid-RUN or in DONE: result discarded, out_valid=0 next cycle; the following request computes correctly from clean state.
- out_sum bytes not yet written in the current op retain stale values; only valid when out_valid=1.
- No X propagation: operand registers reset to 0.

Decomposition:
- Shared package adder_seq_pkg holds:
  - the state enum {IDLE, RUN, DONE};
  - BYTE_W=8;
  - helper function ovf_calc(a_msb, b_msb, s_msb).
- Sub-module: the existing `adder` (8-bit Kogge-Stone) instantiated once. No new sub-module; byte mux and carry register stay in the top.

Test Plan:
1. NBYTES=4, add 0xFFFFFFFF + 0x00000001, cin=0 -> out_sum=0x00000000, out_cout=1, out_ovf=0, out_valid at T+4.
2. add 0x7FFFFFFF + 0x00000001, cin=0 -> out_sum=0x80000000, out_cout=0, out_ovf=1.
3. sub 0x00000005 - 0x00000007, cin=0 -> out_sum=0xFFFFFFFE, out_cout=0, out_ovf=0. Then sub 5 - 3 -> out_sum=0x00000002, out_cout=1.
4. Hold out_ready=0 for 10 cycles after completion -> out_valid stays 1, outputs stable, in_ready=0, new in_valid stalled. Release -> IDLE next cycle, stalled op accepted and correct.
5. Assert rst for 1 cycle while idx=2 -> out_valid=0, in_ready=1 after release. Next op add 0x12345678 + 0x11111111 -> 0x23456789, cout=0.
6. Random 1000 ops with random in_valid/out_ready gaps, NBYTES=1 and 4 -> every result matches reference model {cout,sum}=a+b'+cin'; no lost or duplicated transactions.
